// File: rtl/envelope_vca.sv
// Envelope-controlled VCA: scales signed samples by a Q1.31 gain through a two-stage
// stream pipeline. Define VCA_SMOOTH_EN to add a one-pole smoother on the gain register.
module envelope_vca #(
    parameter int SAMPLE_WIDTH   = 24,
    parameter int ENVELOPE_WIDTH = 32,
    parameter int SMOOTH_SHIFT   = 6
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [ENVELOPE_WIDTH-1:0] envelope_in,
    input  logic [SAMPLE_WIDTH-1:0]   s_tdata,
    input  logic                      s_tvalid,
    output logic                      s_tready,
    output logic [SAMPLE_WIDTH-1:0]   m_tdata,
    output logic                      m_tvalid,
    input  logic                      m_tready,
    output logic                      active
);

    localparam int SW = SAMPLE_WIDTH;
    localparam int EW = ENVELOPE_WIDTH;
    localparam int PW = SW + EW + 1;
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (EW - 2);

    logic [EW-1:0] r_gain;
    logic          r_active;
    logic          r_run;
    logic          r_s1_valid;
    logic [SW-1:0] r_s1_data;
    logic [EW-1:0] r_s1_gain;
    logic          r_m_valid;
    logic [SW-1:0] r_m_data;

    logic [EW-1:0]          w_env;
    logic [EW-1:0]          w_gain_nxt;
    logic                   w_s2_adv;
    logic                   w_s1_adv;
    logic                   w_acc;
    logic signed [PW-1:0]   w_prod;
    logic [SW-1:0]          w_res;

    // Negative-looking envelopes are clamped to unity before anything else sees them.
    assign w_env = envelope_in[EW-1] ? {1'b0, {(EW-1){1'b1}}} : envelope_in;

`ifdef VCA_SMOOTH_EN
    localparam logic [EW:0] SNAP = {{EW{1'b0}}, 1'b1} << SMOOTH_SHIFT;

    logic signed [EW:0] w_diff;
    logic [EW:0]        w_abs;
    logic [EW-1:0]      w_step;

    assign w_diff     = $signed({1'b0, w_env}) - $signed({1'b0, r_gain});
    assign w_abs      = w_diff[EW] ? -w_diff : w_diff;
    assign w_step     = EW'(w_diff >>> SMOOTH_SHIFT);
    // Result always lies between old gain and env, so modulo-EW addition is exact.
    assign w_gain_nxt = (w_abs < SNAP) ? w_env : (r_gain + w_step);
`else
    assign w_gain_nxt = w_env;
`endif

    assign w_s2_adv = ~r_m_valid | m_tready;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;
    assign s_tready = r_run & w_s1_adv;
    assign w_acc    = s_tvalid & s_tready;

    assign w_prod = $signed(r_s1_data) * $signed({1'b0, r_s1_gain});
    assign w_res  = SW'((w_prod + RND) >>> (EW - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gain     <= '0;
            r_active   <= 1'b0;
            r_run      <= 1'b0;
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_gain  <= '0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
        end else begin
            r_run <= 1'b1;
            if (w_acc) begin
                r_gain   <= w_gain_nxt;
                r_active <= (w_gain_nxt != '0);
            end
            // S1 samples the gain register before this edge's update.
            if (w_s1_adv) begin
                r_s1_valid <= w_acc;
                if (w_acc) begin
                    r_s1_data <= s_tdata;
                    r_s1_gain <= r_gain;
                end
            end
            if (w_s2_adv) begin
                r_m_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_m_data <= w_res;
                end
            end
        end
    end

    assign m_tdata  = r_m_data;
    assign m_tvalid = r_m_valid;
    assign active   = r_active;

endmodule

// File: tb/tb_envelope_vca.sv
// Self-checking bench for envelope_vca: directed vector table, stall/reset sequences and
// randomized traffic against a queue-based reference model (honours VCA_SMOOTH_EN).
module tb_envelope_vca;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] envelope_in;
    logic [23:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [23:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        active;

    envelope_vca dut (
        .clk         (clk),
        .rst         (rst),
        .envelope_in (envelope_in),
        .s_tdata     (s_tdata),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .active      (active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain integer arithmetic on the documented rules.
    function automatic logic [31:0] clamp(input logic [31:0] e);
        return e[31] ? 32'h7FFF_FFFF : e;
    endfunction

    function automatic logic [23:0] ref_out(input logic [23:0] s, input logic [31:0] g);
        longint p;
        p = longint'($signed(s)) * longint'({32'b0, g});
        p = (p + (64'sd1 <<< 30)) >>> 31;
        return p[23:0];
    endfunction

    function automatic logic [31:0] ref_gain(input logic [31:0] g, input logic [31:0] e);
`ifdef VCA_SMOOTH_EN
        longint d;
        longint n;
        d = longint'({32'b0, e}) - longint'({32'b0, g});
        if (d > -64 && d < 64) return e;
        n = longint'({32'b0, g}) + (d >>> 6);
        return n[31:0];
`else
        return e + 32'(g - g);
`endif
    endfunction

    logic [23:0] q[$];
    logic [31:0] g_model = '0;
    logic        have_hold = 1'b0;
    logic [23:0] hold_data = '0;
    int          post_edges = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) post_edges <= 0;
        else if (post_edges < 2) post_edges <= post_edges + 1;
    end

    // Scoreboard: at each negedge predict what the coming posedge does.
    always @(negedge clk) begin
        logic [23:0] e;
        if (rst) begin
            q.delete();
            g_model   = '0;
            have_hold = 1'b0;
        end else begin
            if (post_edges >= 1) begin
                chk("ready_rule", s_tready, (q.size() < 2) || m_tready);
                chk("active_rule", active, g_model != 0);
            end
            if (have_hold) begin
                chk("stall_valid", m_tvalid, 1'b1);
                chk("stall_data", m_tdata, hold_data);
            end
            if (m_tvalid && m_tready) begin
                if (q.size() == 0) chk("unexpected_out", 1'b1, 1'b0);
                else begin
                    e = q.pop_front();
                    chk("sb_data", m_tdata, e);
                end
            end
            have_hold = m_tvalid && !m_tready;
            hold_data = m_tdata;
            if (s_tvalid && s_tready) begin
                q.push_back(ref_out(s_tdata, g_model));
                g_model = ref_gain(g_model, clamp(envelope_in));
            end
        end
    end

    task automatic send_one(input logic [31:0] env, input logic [23:0] smp, output logic [23:0] got);
        int n;
        m_tready    = 1'b1;
        envelope_in = env;
        s_tdata     = smp;
        s_tvalid    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!s_tready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!s_tready) chk("send_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        s_tvalid    = 1'b0;
        envelope_in = $urandom;
        s_tdata     = 24'($urandom);
        @(posedge clk); #1;
        chk("latency_valid", m_tvalid, 1'b1);
        got = m_tdata;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [31:0] env;
        logic [23:0] smp;
        logic [23:0] exp;
        logic        exp_act;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[11];
        logic [23:0] got;
        logic [23:0] prev;
        logic [31:0] g;
        int          sent;
        int          outs;
        int          cyc;
        logic        acc;
        logic        hs;
        logic        saw_block;
        logic        mono_ok;

        rst = 1'b1; envelope_in = '0; s_tdata = '0; s_tvalid = 1'b0; m_tready = 1'b1;
        #1;
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_s_tready", s_tready, 1'b0);
        chk("rst_active", active, 1'b0);
        chk("rst_m_tdata", m_tdata, 24'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        chk("ready_low_before_edge", s_tready, 1'b0);
        @(posedge clk); #1;
        chk("ready_after_release", s_tready, 1'b1);

`ifndef VCA_SMOOTH_EN
        // Each output uses the gain left by the previous row's acceptance.
        tbl[0]  = '{32'h7FFF_FFFF, 24'h000123, 24'h000000, 1'b1};
        tbl[1]  = '{32'h7FFF_FFFF, 24'h400000, 24'h400000, 1'b1};
        tbl[2]  = '{32'h7FFF_FFFF, 24'h800000, 24'h800000, 1'b1};
        tbl[3]  = '{32'h4000_0000, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
        tbl[4]  = '{32'h4000_0000, 24'h7FFFFF, 24'h400000, 1'b1};
        tbl[5]  = '{32'h0000_0000, 24'h7FFFFF, 24'h400000, 1'b0};
        tbl[6]  = '{32'h0000_0000, 24'h555555, 24'h000000, 1'b0};
        tbl[7]  = '{32'h8000_0000, 24'h123456, 24'h000000, 1'b1};
        tbl[8]  = '{32'h8000_0000, 24'h123456, 24'h123456, 1'b1};
        tbl[9]  = '{32'hFFFF_FFFF, 24'h800000, 24'h800000, 1'b1};
        tbl[10] = '{32'h7FFF_FFFF, 24'h7FFFFF, 24'h7FFFFF, 1'b1};
        for (int i = 0; i < 11; i++) begin
            send_one(tbl[i].env, tbl[i].smp, got);
            chk($sformatf("tbl%0d_data", i), got, tbl[i].exp);
            chk($sformatf("tbl%0d_active", i), active, tbl[i].exp_act);
        end
`endif

        // Stream of 8 incrementing samples with downstream stalled for cycles 3-6.
        send_one(32'h7FFF_FFFF, 24'h0, got);
        sent = 0; outs = 0; cyc = 0; saw_block = 1'b0;
        envelope_in = 32'h7FFF_FFFF; s_tdata = 24'd1; s_tvalid = 1'b1;
        while ((sent < 8 || outs < 8) && cyc < 60) begin
            m_tready = !(cyc >= 3 && cyc <= 6);
            @(negedge clk);
            acc = s_tvalid && s_tready;
            hs  = m_tvalid && m_tready;
            if (!m_tready && !s_tready) saw_block = 1'b1;
            @(posedge clk); #1;
            if (acc) begin
                sent++;
                s_tdata = s_tdata + 24'd1;
                if (sent == 8) s_tvalid = 1'b0;
            end
            if (hs) outs++;
            cyc++;
        end
        m_tready = 1'b1;
        chk("stream_sent", sent, 8);
        chk("stream_outs", outs, 8);
        chk("stream_blocked", saw_block, 1'b1);

        // Reset with two samples in flight.
        m_tready = 1'b0; envelope_in = 32'h7FFF_FFFF; s_tdata = 24'h000111; s_tvalid = 1'b1;
        @(posedge clk); #1;
        s_tdata = 24'h000222;
        @(posedge clk); #1;
        s_tvalid = 1'b0;
        chk("pre_rst_valid", m_tvalid, 1'b1);
        #1 rst = 1'b1;
        #1;
        chk("async_m_tvalid", m_tvalid, 1'b0);
        chk("async_s_tready", s_tready, 1'b0);
        chk("async_active", active, 1'b0);
        chk("async_m_tdata", m_tdata, 24'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0; m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_stale_out", m_tvalid, 1'b0);
        end
        g = '0;
        send_one(32'h7FFF_FFFF, 24'h000333, got);
        chk("post_rst_first", got, ref_out(24'h000333, g));
        g = ref_gain(g, 32'h7FFF_FFFF);
        send_one(32'h7FFF_FFFF, 24'h000333, got);
        chk("post_rst_second", got, ref_out(24'h000333, g));

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 1500; i++) begin
            s_tvalid    = ($urandom % 4) != 0;
            m_tready    = ($urandom % 3) != 0;
            s_tdata     = 24'($urandom);
            envelope_in = $urandom;
            @(posedge clk); #1;
        end
        s_tvalid = 1'b0; m_tready = 1'b1;
        for (int i = 0; i < 6; i++) @(posedge clk);
        #1;
        chk("drain_empty", q.size(), 0);

`ifdef VCA_SMOOTH_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send_one(32'h7FFF_FFFF, 24'h7FFFFF, got);
        chk("smooth_first", got, 24'h0);
        send_one(32'h7FFF_FFFF, 24'h7FFFFF, got);
        chk("smooth_second", got, ref_out(24'h7FFFFF, 32'h01FF_FFFF));
        mono_ok = 1'b1;
        prev = got;
        for (int i = 0; i < 1300; i++) begin
            send_one(32'h7FFF_FFFF, 24'h7FFFFF, got);
            if (got < prev) mono_ok = 1'b0;
            prev = got;
        end
        chk("smooth_monotonic", mono_ok, 1'b1);
        chk("smooth_final", got, 24'h7FFFFF);
        chk("smooth_active", active, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
